multiply_8bits: RTL and testbench

Clocked unsigned 4×4-bit array multiplier producing an 8-bit product. Operands are captured on the rising clock edge and the full-precision product is presented on a registered output. It sits in the datapath wherever a small fixed-width product is needed. It accepts one new operand pair every cycle, and a valid flag tracks each result.

---
 rtl/multiply_8bits_pkg.sv | 18 +
 rtl/mult_full_adder.sv | 17 +
 rtl/multiply_8bits.sv | 176 +++++++++++++++++
 tb/tb_multiply_8bits.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/multiply_8bits_pkg.sv
// rtl/multiply_8bits_pkg.sv - shared constants and types for the 4x4 array multiplier
// Purpose: operand/product widths, their typedefs, and the row index after
//          which the optional pipeline register is placed.
// Ports:   none (package).
package multiply_8bits_pkg;

   localparam int MULT_IN_W  = 4;
   localparam int MULT_OUT_W = 8;

   typedef logic [MULT_IN_W-1:0]  mult_opnd_t;
   typedef logic [MULT_OUT_W-1:0] mult_prod_t;

   // Rows are numbered 1..in_w-1; integer in_w/2 equals ceil((in_w-1)/2).
   function automatic int mult_pipe_row(input int in_w);
      return in_w / 2;
   endfunction

endpackage

// File: rtl/mult_full_adder.sv
// rtl/mult_full_adder.sv - one-bit combinational full adder cell of the multiplier array
// Purpose: sum/carry of three input bits.
// Ports:   a, b, cin - addend bits; sum - a^b^cin; cout - carry out.
module mult_full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   always_comb begin
      sum  = a ^ b ^ cin;
      cout = (a & b) | (cin & (a ^ b));
   end

endmodule

// File: rtl/multiply_8bits.sv
// rtl/multiply_8bits.sv - clocked unsigned IN_W x IN_W ripple-array multiplier
// Purpose: product = inp1 * inp2, loaded into a register when in_valid is high.
//          Optional macro MULTIPLY_8BITS_PIPE_EN inserts a register stage
//          after array row IN_W/2 (latency 2 instead of 1); that build
//          assumes IN_W >= 3.
// Ports:   product   - registered unsigned product (OUT_W = 2*IN_W bits)
//          inp1/inp2 - unsigned operands, sampled on the rising edge
//          clk       - rising-edge clock
//          rst_n     - asynchronous active-low reset, clears all registers
//          in_valid  - operands valid this cycle
//          out_valid - product holds the result issued LAT cycles earlier
module multiply_8bits
   import multiply_8bits_pkg::*;
#(
   parameter int IN_W  = MULT_IN_W,
   parameter int OUT_W = MULT_OUT_W
) (
   output logic [OUT_W-1:0] product,
   input  logic [IN_W-1:0]  inp1,
   input  logic [IN_W-1:0]  inp2,
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             out_valid
);

   localparam int PIPE_ROW = mult_pipe_row(IN_W);

   logic [IN_W-1:0][IN_W-1:0] pp_d;      // pp_d[i][j] = inp1[j] & inp2[i]
   logic [IN_W-1:0]           row_lsb;   // bit r of the product, produced by row r
   logic [IN_W-1:0]           lo_bits;
   logic [OUT_W-1:0]          prod_full;
   logic [OUT_W-1:0]          product_d, product_q;
   logic                      out_valid_d, out_valid_q;
   logic                      res_valid;

`ifdef MULTIPLY_8BITS_PIPE_EN
   logic [IN_W-1:0]                     stg_s_d, stg_s_q;
   logic                                stg_c_d, stg_c_q;
   logic [PIPE_ROW:0]                   stg_lo_d, stg_lo_q;
   logic [IN_W-1:PIPE_ROW+1][IN_W-1:0]  stg_pp_d, stg_pp_q;
   logic                                stg_v_d, stg_v_q;
`endif

   always_comb begin
      pp_d = '0;
      for (int i = 0; i < IN_W; i++) begin
         for (int j = 0; j < IN_W; j++) begin
            pp_d[i][j] = inp1[j] & inp2[i];
         end
      end
   end

   assign row_lsb[0] = pp_d[0][0];

   // Each row adds its partial products to the previous row's sum shifted
   // right by one; the shifted-out LSB is a finished product bit and the
   // row's carry out becomes the new top bit.
   for (genvar r = 1; r < IN_W; r++) begin : g_row
      logic [IN_W-1:0] ps;
      logic            pc;
      logic [IN_W-1:0] pa;
      logic [IN_W-1:0] s;
      logic            c;

      if (r == 1) begin : g_src_first
         assign ps = pp_d[0];
         assign pc = 1'b0;
      end
`ifdef MULTIPLY_8BITS_PIPE_EN
      else if (r == PIPE_ROW + 1) begin : g_src_stage
         assign ps = stg_s_q;
         assign pc = stg_c_q;
      end
`endif
      else begin : g_src_prev
         assign ps = g_row[r-1].s;
         assign pc = g_row[r-1].c;
      end

`ifdef MULTIPLY_8BITS_PIPE_EN
      if (r > PIPE_ROW) begin : g_pp_stage
         assign pa = stg_pp_q[r];
      end else begin : g_pp_live
         assign pa = pp_d[r];
      end
`else
      assign pa = pp_d[r];
`endif

      for (genvar j = 0; j < IN_W; j++) begin : g_col
         logic b, ci, co, so;

         if (j == 0) begin : g_ci_zero
            assign ci = 1'b0;
         end else begin : g_ci_chain
            assign ci = g_col[j-1].co;
         end

         if (j == IN_W - 1) begin : g_b_carry
            assign b = pc;
         end else begin : g_b_sum
            assign b = ps[j+1];
         end

         mult_full_adder u_fa (
            .a    (pa[j]),
            .b    (b),
            .cin  (ci),
            .sum  (so),
            .cout (co)
         );

         assign s[j] = so;
      end

      assign c          = g_col[IN_W-1].co;
      assign row_lsb[r] = s[0];
   end

`ifdef MULTIPLY_8BITS_PIPE_EN
   always_comb begin
      stg_v_d   = in_valid;
      stg_s_d   = g_row[PIPE_ROW].s;
      stg_c_d   = g_row[PIPE_ROW].c;
      stg_lo_d  = row_lsb[PIPE_ROW:0];
      stg_pp_d  = pp_d[IN_W-1:PIPE_ROW+1];
      res_valid = stg_v_q;
      lo_bits   = {row_lsb[IN_W-1:PIPE_ROW+1], stg_lo_q};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stg_v_q  <= 1'b0;
         stg_s_q  <= '0;
         stg_c_q  <= 1'b0;
         stg_lo_q <= '0;
         stg_pp_q <= '0;
      end else begin
         stg_v_q  <= stg_v_d;
         stg_s_q  <= stg_s_d;
         stg_c_q  <= stg_c_d;
         stg_lo_q <= stg_lo_d;
         stg_pp_q <= stg_pp_d;
      end
   end
`else
   always_comb begin
      res_valid = in_valid;
      lo_bits   = row_lsb;
   end
`endif

   always_comb begin
      prod_full   = {g_row[IN_W-1].c, g_row[IN_W-1].s[IN_W-1:1], lo_bits};
      product_d   = product_q;
      out_valid_d = res_valid;
      if (res_valid) begin
         product_d = prod_full;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         product_q   <= '0;
         out_valid_q <= 1'b0;
      end else begin
         product_q   <= product_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign product   = product_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_multiply_8bits.sv
// tb/tb_multiply_8bits.sv - directed self-checking bench for multiply_8bits
module tb_multiply_8bits;
   import multiply_8bits_pkg::*;

`ifdef MULTIPLY_8BITS_PIPE_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   mult_opnd_t inp1, inp2;
   mult_prod_t product;
   logic       out_valid;

   int n_checks = 0;
   int n_errors = 0;

   mult_opnd_t qa[$];
   mult_opnd_t qb[$];
   mult_prod_t qe[$];

   multiply_8bits dut (
      .product   (product),
      .inp1      (inp1),
      .inp2      (inp2),
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .out_valid (out_valid)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int a, input int b, input int e);
      qa.push_back(mult_opnd_t'(a));
      qb.push_back(mult_opnd_t'(b));
      qe.push_back(mult_prod_t'(e));
   endtask

   // Issue every queued pair on consecutive cycles and check each result
   // arrives LAT cycles later with out_valid high, then drops afterwards.
   task automatic run_stream(input string tag);
      int n = qa.size();
      for (int c = 0; c < n + LAT - 1; c++) begin
         if (c < n) begin
            inp1     = qa[c];
            inp2     = qb[c];
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         step();
         if (c < LAT - 1) begin
            check_eq({tag, "_early_vld"}, {31'd0, out_valid}, 32'd0);
         end else begin
            check_eq({tag, "_prod"}, {24'd0, product}, {24'd0, qe[c-LAT+1]});
            check_eq({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
         end
      end
      in_valid = 1'b0;
      step();
      check_eq({tag, "_vld_after"}, {31'd0, out_valid}, 32'd0);
      qa.delete();
      qb.delete();
      qe.delete();
   endtask

   initial begin
      logic seen_vld;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      inp1     = '0;
      inp2     = '0;
      repeat (2) step();
      check_eq("reset_prod", {24'd0, product}, 32'd0);
      check_eq("reset_vld", {31'd0, out_valid}, 32'd0);
      rst_n = 1'b1;
      step();

      push(5, 10, 50);
      run_stream("p5x10");
      push(15, 15, 225);
      run_stream("p15x15");
      push(0, 9, 0);
      run_stream("p0x9");
      push(1, 13, 13);
      run_stream("p1x13");

      push(3, 4, 12);
      push(7, 7, 49);
      push(12, 5, 60);
      run_stream("b2b");

      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            push(a, b, a * b);
         end
      end
      run_stream("all");

      // Reset while a result is in flight.
      inp1     = 4'd6;
      inp2     = 4'd7;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check_eq("rst_async_prod", {24'd0, product}, 32'd0);
      check_eq("rst_async_vld", {31'd0, out_valid}, 32'd0);
      step();
      rst_n    = 1'b1;
      seen_vld = 1'b0;
      repeat (4) begin
         step();
         seen_vld = seen_vld | out_valid;
      end
      check_eq("rst_no_late_vld", {31'd0, seen_vld}, 32'd0);
      check_eq("rst_prod_stays", {24'd0, product}, 32'd0);

      // Hold with in_valid low while operands wander.
      push(9, 9, 81);
      run_stream("p9x9");
      for (int k = 0; k < 4; k++) begin
         inp1 = mult_opnd_t'(k * 3 + 2);
         inp2 = mult_opnd_t'(15 - k);
         step();
         check_eq("hold_prod", {24'd0, product}, 32'd81);
         check_eq("hold_vld", {31'd0, out_valid}, 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
